// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns; entry N is hex digit N.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Double-buffered multiplexed scan controller for a common-anode 7-segment display.
// Optional SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits at frame commit.
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DATA_W  = 4 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_e             state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic [DATA_W-1:0]       active_data;
    logic [NUM_DIGITS-1:0]   active_en;

    logic [3:0]              cur_nib_c;
    logic [6:0]              drive_seg_c;
    logic [NUM_DIGITS-1:0]   drive_an_c;
    logic [NUM_DIGITS-1:0]   commit_en_c;

    // Nibble and anode pattern for the digit about to be driven.
    always_comb begin
        cur_nib_c  = 4'h0;
        drive_an_c = AN_OFF;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == idx) begin
                cur_nib_c     = active_data[i*4 +: 4];
                drive_an_c[i] = ~active_en[i];
            end
        end
    end

    hex_to_7seg u_dec (
        .hex   (cur_nib_c),
        .seg_c (drive_seg_c)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic lz_scan_c;

    // Walk down from the top, darkening enabled zeros until the first nonzero digit.
    always_comb begin
        commit_en_c = shadow_en;
        lz_scan_c   = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (lz_scan_c && shadow_en[i]) begin
                if (shadow_data[i*4 +: 4] == 4'h0) begin
                    commit_en_c[i] = 1'b0;
                end else begin
                    lz_scan_c = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        commit_en_c = shadow_en;
    end
`endif

    // Scan FSM, double buffer and registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            shadow_data <= '0;
            shadow_en   <= '0;
            active_data <= '0;
            active_en   <= '0;
            load_ready  <= 1'b1;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (load_valid && load_ready) begin
                shadow_data <= load_data;
                shadow_en   <= load_en;
                load_ready  <= 1'b0;
            end

            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        seg   <= drive_seg_c;
                        an    <= drive_an_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        seg   <= SEG_OFF;
                        an    <= AN_OFF;
                        if (idx == IDX_LAST) begin
                            idx         <= '0;
                            frame_start <= 1'b1;
                            // Frame boundary: ready is low here, so no transfer races the commit.
                            if (!load_ready) begin
                                active_data <= shadow_data;
                                active_en   <= commit_en_c;
                                load_ready  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Accepts a packed hex/BCD frame through a valid/ready handshake and double-buffers it, so updates commit only at frame boundaries (no tearing).
- Sequences digits with a fixed dwell time plus an anti-ghosting blank interval; drives the active-low seg/an pins directly.
- Sits between the binary_to_bcd front end (or any value producer) and the display pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (anode width); range 2-8.
- DWELL_CYCLES, 100000, clocks each digit is driven (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, 1000, clocks all anodes are off before each digit; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  producer has a new frame.
- load_ready  out  1  scheduler can accept a frame.
- load_data  in  4*NUM_DIGITS  nibble i = digit i, hex value 0-F; digit 0 is rightmost.
- load_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit dark.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  active-low anodes.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (synchronous, active-high; one clock; one reset port named reset):
  - an = all ones; seg = 7'b1111111; frame_start = 0; load_ready = 1.
  - state = BLANK; digit index = 0; dwell counter = 0.
  - Shadow and active data/enable registers = 0; pending = 0.
- Reset mid-operation: the same values take effect on the next edge. Any pending frame is discarded.
- FSM:
  - BLANK: an = all ones, seg = all ones, held for exactly BLANK_CYCLES clocks, then go to DRIVE.
  - DRIVE: held for exactly DWELL_CYCLES clocks.
    - an[idx] = 0 (others 1) if active_en[idx], else an = all ones.
    - seg = decode(active nibble idx).
    - On exit: idx increments, wrapping NUM_DIGITS-1 -> 0, and the FSM returns to BLANK.
  - A disabled digit still consumes its slot, so brightness of the other digits stays constant.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES).
- Output registering: seg, an and frame_start are registered, computed from next-state, so they change on the same edge the FSM enters a state. Outputs are glitch-free.
- Handshake and double buffering:
  - load_ready = !pending.
  - Transfer occurs on (load_valid && load_ready): shadow <= load_data/load_en, pending <= 1.
  - Commit occurs on the edge where idx wraps to 0 and the FSM enters BLANK. If pending, active <= shadow and pending <= 0.
  - frame_start pulses on that same edge, whether or not a commit happens.
  - Commit and a producer asserting valid in the same cycle: ready is 0, so no transfer; ready rises the next cycle.
  - load_data is ignored while ready = 0. The producer must hold data until the transfer.
- Decode: standard hex, active low. Examples: 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 8 -> 0000000, F -> 0001110.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - At commit, the enable mask is additionally cleared for leading zero digits, scanning from the highest enabled digit downward until the first nonzero digit.
  - Digit 0 is never blanked.
  - The result is registered into the active enable mask, so no extra scan-path logic is added.
- Undefined: active enable = committed load_en unchanged.

Decomposition:
- Package seg_scan_pkg:
  - State enum {BLANK, DRIVE}.
  - SEG_OFF = 7'b1111111.
  - Hex-to-segment constant table.
- Sub-module: hex_to_7seg (4-bit in, 7-bit active-low out, combinational), instantiated once on the selected active nibble.
- Counters, FSM and buffers stay in seg_scan_scheduler.

Test Plan (NUM_DIGITS=8, DWELL_CYCLES=4, BLANK_CYCLES=2):
1. Assert reset for 3 cycles -> an=8'hFF, seg=7'h7F, load_ready=1, frame_start=0.
2. Load data=32'h0000_0123, en=8'h07 -> ready drops to 0 the next cycle; after the next frame_start:
   - Slot 0: an=8'hFE, seg=0110000 for exactly 4 cycles.
   - Slot 1: an=8'hFD, seg=0100100.
   - Slot 2: an=8'hFB, seg=1111001.
   - Slots 3-7: an=8'hFF.
3. Load a second frame while pending -> load_ready=0, the old frame continues displaying; the new frame appears only after the following frame_start.
4. Free-run -> frame_start period exactly 48 cycles; an=8'hFF for exactly 2 cycles between every pair of digits.
5. Assert reset in mid-DRIVE with a frame pending -> next cycle an=8'hFF, pending cleared, load_ready=1; the first post-reset frame is all dark.
6. Load data=32'h0000_0105, en=8'hFF:
   - Macro defined: digits 3-7 dark, digit 1 shows 1000000.
   - Macro undefined: digits 3-7 show 1000000.
